// File: rtl/multibit_sequential_multiplicator.sv
// Multi-bit-per-cycle sequential multiplier.
// Each CALC cycle retires BITS_PER_CYCLE multiplier bits, LSB first, so one
// product takes WIDTH/BITS_PER_CYCLE clocks.
// Optional feature macro: SIGNED_MODE_EN adds the signed_in port and
// two's-complement operation selected per operation.
module multibit_sequential_multiplicator #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                 clock,
  input  logic                 reset_in,
  input  logic                 start_in,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplier_in,
`ifdef SIGNED_MODE_EN
  input  logic                 signed_in,
`endif
  output logic [2*WIDTH-1:0]   product_out,
  output logic                 overflow_out,
  output logic                 done_out,
  output logic                 busy_out
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
`ifdef SIGNED_MODE_EN
  logic             signed_q, signed_d;
`endif

  logic [PW-1:0]    partial;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    finalSum;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clock) begin
    if (reset_in) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      acc_q      <= '0;
      product_q  <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
`ifdef SIGNED_MODE_EN
      signed_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      product_q  <= product_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
`ifdef SIGNED_MODE_EN
      signed_q   <= signed_d;
`endif
    end
  end

  // Next-state logic: the multiplicand shifts left and the multiplier shifts
  // right each step, so the low multiplier digit always lines up with the
  // current weight; in signed mode a negative multiplier is fixed up on the
  // last step by subtracting the multiplicand at weight 2^WIDTH.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    product_d  = product_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
`ifdef SIGNED_MODE_EN
    signed_d   = signed_q;
`endif
    partial    = mcand_q * {{(PW-BITS_PER_CYCLE){1'b0}}, mplier_q[BITS_PER_CYCLE-1:0]};
    sum        = acc_q + partial;
    finalSum   = sum;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_in) begin
          state_d  = CALC;
          mplier_d = multiplier_in;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef SIGNED_MODE_EN
          signed_d = signed_in;
          mcand_d  = (signed_in && multiplicand_in[WIDTH-1]) ?
                     {{WIDTH{1'b1}}, multiplicand_in} :
                     {{WIDTH{1'b0}}, multiplicand_in};
`else
          mcand_d  = {{WIDTH{1'b0}}, multiplicand_in};
`endif
        end
      end
      CALC: begin
        acc_d    = sum;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = DONE;
`ifdef SIGNED_MODE_EN
          if (signed_q && mplier_q[BITS_PER_CYCLE-1]) begin
            finalSum = sum - (mcand_q << BITS_PER_CYCLE);
          end
          if (signed_q) begin
            overflow_d = !((&finalSum[PW-1:WIDTH-1]) || !(|finalSum[PW-1:WIDTH-1]));
          end else begin
            overflow_d = |finalSum[PW-1:WIDTH];
          end
`else
          overflow_d = |finalSum[PW-1:WIDTH];
`endif
          product_d = finalSum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs follow the state directly; results come from the hold registers.
  always_comb begin
    busy_out     = (state_q == CALC);
    done_out     = (state_q == DONE);
    product_out  = product_q;
    overflow_out = overflow_q;
  end

endmodule

// File: tb/tb_multibit_sequential_multiplicator.sv
// Self-checking bench for multibit_sequential_multiplicator (WIDTH=8, 2 bits/cycle).
// Directed cases with literal results, then randomized traffic with random
// starts and occasional resets, all checked every cycle against an arithmetic model.
module tb_multibit_sequential_multiplicator;

  localparam int WIDTH = 8;
  localparam int BPC   = 2;
  localparam int STEPS = WIDTH / BPC;
  localparam int PW    = 2 * WIDTH;

  logic             clock = 1'b0;
  logic             reset_in;
  logic             start_in;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             signedIn;
  logic [PW-1:0]    product_out;
  logic             overflow_out;
  logic             done_out;
  logic             busy_out;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state: cycles left in the current operation, done flag, held result.
  bit            mValid = 1'b0;
  int            mLeft  = 0;
  bit            mDone  = 1'b0;
  logic [PW-1:0] mProd  = '0;
  bit            mOv    = 1'b0;
  logic [PW-1:0] pendProd;
  bit            pendOv;

  multibit_sequential_multiplicator #(
    .WIDTH(WIDTH),
    .BITS_PER_CYCLE(BPC)
  ) dut (
    .clock(clock),
    .reset_in(reset_in),
    .start_in(start_in),
    .multiplicand_in(multiplicand),
    .multiplier_in(multiplier),
`ifdef SIGNED_MODE_EN
    .signed_in(signedIn),
`endif
    .product_out(product_out),
    .overflow_out(overflow_out),
    .done_out(done_out),
    .busy_out(busy_out)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference product from plain integer arithmetic.
  task automatic refMultiply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input bit sgn, output logic [PW-1:0] p, output bit ov);
    longint va;
    longint vb;
    longint full;
    va = longint'(a);
    vb = longint'(b);
    if (sgn && a[WIDTH-1]) va = va - (longint'(1) << WIDTH);
    if (sgn && b[WIDTH-1]) vb = vb - (longint'(1) << WIDTH);
    full = va * vb;
    p = full[PW-1:0];
    if (sgn) ov = (full < -(longint'(1) << (WIDTH-1))) || (full >= (longint'(1) << (WIDTH-1)));
    else     ov = (full >= (longint'(1) << WIDTH));
  endtask

  // Model update on each rising edge from the inputs the DUT sees.
  always @(posedge clock) begin
    bit sgn;
`ifdef SIGNED_MODE_EN
    sgn = signedIn;
`else
    sgn = 1'b0;
`endif
    if (reset_in) begin
      mValid = 1'b1;
      mLeft  = 0;
      mDone  = 1'b0;
      mProd  = '0;
      mOv    = 1'b0;
    end else if (mLeft == 0 && start_in) begin
      refMultiply(multiplicand, multiplier, sgn, pendProd, pendOv);
      mLeft = STEPS;
      mDone = 1'b0;
    end else if (mLeft > 0) begin
      mLeft = mLeft - 1;
      if (mLeft == 0) begin
        mDone = 1'b1;
        mProd = pendProd;
        mOv   = pendOv;
      end
    end else begin
      mDone = 1'b0;
    end
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clock) begin
    if (mValid) begin
      checkOutput("busy", 64'(busy_out), 64'(mLeft > 0));
      checkOutput("done", 64'(done_out), 64'(mDone));
      checkOutput("product", 64'(product_out), 64'(mProd));
      checkOutput("overflow", 64'(overflow_out), 64'(mOv));
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic sgn);
    multiplicand = a;
    multiplier   = b;
    signedIn     = sgn;
    start_in     = 1'b1;
    @(negedge clock);
    start_in     = 1'b0;
  endtask

  task automatic waitForDone(output int lat);
    lat = 0;
    while (!done_out && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("doneSeen", 64'(done_out), 64'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] r;
    reset_in     = 1'b1;
    start_in     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    signedIn     = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("resetProduct", 64'(product_out), 64'h0);
    checkOutput("resetBusy", 64'(busy_out), 64'h0);
    checkOutput("resetDone", 64'(done_out), 64'h0);
    checkOutput("resetOverflow", 64'(overflow_out), 64'h0);
    reset_in = 1'b0;
    @(negedge clock);

    applyStimulus(8'd13, 8'd11, 1'b0);
    checkOutput("busyAfterStart", 64'(busy_out), 64'h1);
    waitForDone(lat);
    checkOutput("latency13x11", 64'(lat), 64'(STEPS));
    checkOutput("prod13x11", 64'(product_out), 64'h008F);
    checkOutput("ovf13x11", 64'(overflow_out), 64'h0);
    @(negedge clock);
    checkOutput("doneOnePulse", 64'(done_out), 64'h0);
    checkOutput("prodHeld", 64'(product_out), 64'h008F);

    applyStimulus(8'd255, 8'd255, 1'b0);
    waitForDone(lat);
    checkOutput("prod255x255", 64'(product_out), 64'hFE01);
    checkOutput("ovf255x255", 64'(overflow_out), 64'h1);
    @(negedge clock);

`ifdef SIGNED_MODE_EN
    applyStimulus(8'hFD, 8'h05, 1'b1);
    waitForDone(lat);
    checkOutput("prodSignedM3x5", 64'(product_out), 64'hFFF1);
    checkOutput("ovfSignedM3x5", 64'(overflow_out), 64'h0);
    @(negedge clock);
    applyStimulus(8'h80, 8'h80, 1'b1);
    waitForDone(lat);
    checkOutput("prodSigned80x80", 64'(product_out), 64'h4000);
    checkOutput("ovfSigned80x80", 64'(overflow_out), 64'h1);
    @(negedge clock);
`endif

    applyStimulus(8'd7, 8'd9, 1'b0);
    @(negedge clock);
    reset_in = 1'b1;
    @(negedge clock);
    reset_in = 1'b0;
    checkOutput("abortBusy", 64'(busy_out), 64'h0);
    checkOutput("abortProduct", 64'(product_out), 64'h0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("abortNoDone", 64'(done_out), 64'h0);
      @(negedge clock);
    end

    applyStimulus(8'd3, 8'd4, 1'b0);
    multiplicand = 8'd9;
    multiplier   = 8'd9;
    start_in     = 1'b1;
    @(negedge clock);
    start_in     = 1'b0;
    waitForDone(lat);
    checkOutput("prodIgnoredStart", 64'(product_out), 64'h000C);
    applyStimulus(8'd2, 8'd5, 1'b0);
    waitForDone(lat);
    checkOutput("latencyBackToBack", 64'(lat), 64'(STEPS));
    checkOutput("prodBackToBack", 64'(product_out), 64'h000A);
    @(negedge clock);

    for (int c = 0; c < 2000; c++) begin
      r = $urandom;
      case (r[2:0])
        3'd0:    multiplicand = '0;
        3'd1:    multiplicand = '1;
        3'd2:    multiplicand = 8'h80;
        default: multiplicand = r[15:8];
      endcase
      r = $urandom;
      case (r[2:0])
        3'd0:    multiplier = '0;
        3'd1:    multiplier = '1;
        3'd2:    multiplier = 8'h80;
        default: multiplier = r[15:8];
      endcase
      signedIn = r[20];
      start_in = (r[23:22] == 2'b00);
      reset_in = (r[31:26] == 6'd0);
      @(negedge clock);
    end
    reset_in = 1'b0;
    start_in = 1'b0;
    repeat (STEPS + 3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
